// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, state codes, datapath mux codes.
// MC_CONTROL_BNE_EN adds the BNE opcode.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
`ifdef MC_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_4       = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       trap;
  } ctrl_t;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state function of (state, opcode, memory ready).
// MC_CONTROL_BNE_EN routes BNE to BRANCH; otherwise it traps like any unknown opcode.
module mc_next_state
  import mc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output logic [3:0] next_o
);

  always_comb begin
    next_o = S_FETCH;
    case (state_i)
      S_FETCH:  next_o = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: next_o = S_MEMADR;
          OP_RTYPE:     next_o = S_EXEC;
          OP_BEQ:       next_o = S_BRANCH;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       next_o = S_BRANCH;
`endif
          OP_J:         next_o = S_JUMP;
          OP_ADDI:      next_o = S_ADDIEX;
          default:      next_o = S_TRAP;
        endcase
      end
      S_MEMADR: next_o = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_o = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_o = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   next_o = S_RWB;
      S_ADDIEX: next_o = S_ADDIWB;
      // Only Clr leaves TRAP.
      S_TRAP:   next_o = S_TRAP;
      default:  next_o = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU control: state register plus Moore output decode (FETCH IR/PC loads gated by MemReady).
// MC_CONTROL_BNE_EN adds the BranchNe output for BNE branches.
module mc_control
  import mc_pkg::*;
(
  input  logic       Clk,
  input  logic       Clr,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Trap,
`ifdef MC_CONTROL_BNE_EN
  output logic       BranchNe,
`endif
  output logic [3:0] State
);

  state_e     state_q;
  logic [3:0] state_d;
  logic       trap_q;
  logic       trap_d;
  ctrl_t      ctrl;

  mc_next_state u_next (
    .state_i     (state_q),
    .op_i        (Op),
    .mem_ready_i (MemReady),
    .next_o      (state_d)
  );

  assign trap_d = trap_q | (state_d == S_TRAP);

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_FETCH;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_e'(state_d);
      trap_q  <= trap_d;
    end
  end

  always_comb begin
    ctrl      = '0;
    ctrl.trap = trap_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = MemReady;
        ctrl.pc_write  = MemReady;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      default: ;
    endcase
    // Reset dominates: nothing may write or request memory while Clr is held.
    if (Clr) ctrl = '0;
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign Trap        = ctrl.trap;
  assign State       = Clr ? 4'd0 : state_q;

`ifdef MC_CONTROL_BNE_EN
  assign BranchNe = ~Clr & (state_q == S_BRANCH) & (Op == OP_BNE);
`endif

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction state paths and control vectors from a table-level model.
// MC_CONTROL_BNE_EN switches the bench to the BNE-enabled build.
module tb_mc_control;

  logic       Clk = 1'b0;
  logic       Clr = 1'b1;
  logic [5:0] Op = 6'h00;
  logic       MemReady = 1'b1;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Trap;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
`ifdef MC_CONTROL_BNE_EN
  logic       BranchNe;
`endif

  int errors = 0;
  int checks = 0;

  mc_control dut (
    .Clk(Clk), .Clr(Clr), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Trap(Trap),
`ifdef MC_CONTROL_BNE_EN
    .BranchNe(BranchNe),
`endif
    .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       trap;
  } vec_t;

  vec_t dut_vec;
  assign dut_vec = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Trap};

  // Control values each state must present, straight from the state table.
  function automatic vec_t exp_vec(input int s, input logic mr);
    vec_t v = '0;
    case (s)
      0:  begin v.mrd = 1; v.srcb = 2'd1; v.irw = mr; v.pcw = mr; end
      1:  v.srcb = 2'd3;
      2:  begin v.srca = 1; v.srcb = 2'd2; end
      3:  begin v.mrd = 1; v.iord = 1; end
      4:  begin v.rw = 1; v.m2r = 1; end
      5:  begin v.mwr = 1; v.iord = 1; end
      6:  begin v.srca = 1; v.aluop = 2'd2; end
      7:  begin v.rw = 1; v.rdst = 1; end
      8:  begin v.srca = 1; v.aluop = 2'd1; v.pcwc = 1; v.pcsrc = 2'd1; end
      9:  begin v.pcw = 1; v.pcsrc = 2'd2; end
      10: begin v.srca = 1; v.srcb = 2'd2; end
      11: v.rw = 1;
      15: v.trap = 1;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic bit is_wait_state(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  task automatic cyc(input logic clr, input logic mr, input logic [5:0] op);
    @(negedge Clk);
    Clr = clr; MemReady = mr; Op = op;
    #1;
  endtask

  task automatic check_cycle(input string tag, input int s, input logic mr, input logic [5:0] op);
    vec_t e;
    e = exp_vec(s, mr);
    checks++;
    if (State !== 4'(s)) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", tag, State, s);
    end
    checks++;
    if (dut_vec !== e) begin
      errors++;
      $display("FAIL %s ctrl in state %0d: got %h expected %h", tag, s, dut_vec, e);
    end
`ifdef MC_CONTROL_BNE_EN
    checks++;
    if (BranchNe !== ((s == 8) && (op == 6'h05))) begin
      errors++;
      $display("FAIL %s BranchNe: got %b", tag, BranchNe);
    end
`else
    if (op === 6'hxx) $display("unexpected opcode");
`endif
  endtask

  // Runs one instruction starting in FETCH. fw/mw are wait counts in FETCH and
  // in the memory-access state (-1 picks a random count); trap paths hold 10 cycles.
  task automatic run_instr(input string tag, input logic [5:0] op, input int fw, input int mw);
    int path[$];
    int n;
    logic mr;
    path = {0, 1};
    case (op)
      6'h23: path = {path, 2, 3, 4};
      6'h2B: path = {path, 2, 5};
      6'h00: path = {path, 6, 7};
      6'h04: path = {path, 8};
      6'h02: path = {path, 9};
      6'h08: path = {path, 10, 11};
`ifdef MC_CONTROL_BNE_EN
      6'h05: path = {path, 8};
`endif
      default: path = {path, 15};
    endcase
    foreach (path[i]) begin
      if (path[i] == 15) n = 9;
      else if (!is_wait_state(path[i])) n = 0;
      else if (path[i] == 0) n = (fw < 0) ? int'($urandom_range(0, 3)) : fw;
      else n = (mw < 0) ? int'($urandom_range(0, 3)) : mw;
      for (int k = 0; k <= n; k++) begin
        if (is_wait_state(path[i])) mr = (k == n);
        else mr = 1'($urandom_range(0, 1));
        cyc(1'b0, mr, op);
        check_cycle(tag, path[i], mr, op);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 6'h00);
      checks++;
      if (State !== 4'd0 || dut_vec !== vec_t'(0)) begin
        errors++;
        $display("FAIL reset outputs: state %0d ctrl %h expected 0 0", State, dut_vec);
      end
    end
  endtask

  task automatic test_lw();
    run_instr("lw", 6'h23, 0, 0);
  endtask

  task automatic test_sw_wait();
    run_instr("sw_wait", 6'h2B, 0, 3);
  endtask

  task automatic test_back_to_back();
    run_instr("rtype", 6'h00, 0, 0);
    run_instr("beq", 6'h04, 0, 0);
    run_instr("jump", 6'h02, 0, 0);
    run_instr("addi", 6'h08, 1, 0);
  endtask

  task automatic test_random();
    logic [5:0] ops[$] = {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
`ifdef MC_CONTROL_BNE_EN
    ops.push_back(6'h05);
`endif
    for (int i = 0; i < 40; i++)
      run_instr("random", ops[$urandom_range(0, ops.size() - 1)], -1, -1);
  endtask

  task automatic test_trap(input logic [5:0] op);
    run_instr("trap", op, 0, 0);
    cyc(1'b1, 1'b0, op);
    checks++;
    if (State !== 4'd0 || dut_vec !== vec_t'(0)) begin
      errors++;
      $display("FAIL trap clr: state %0d ctrl %h expected 0 0", State, dut_vec);
    end
    run_instr("after_trap", 6'h02, 0, 0);
  endtask

  task automatic test_clr_midwait();
    cyc(1'b0, 1'b1, 6'h23); check_cycle("clr_mid", 0, 1'b1, 6'h23);
    cyc(1'b0, 1'b0, 6'h23); check_cycle("clr_mid", 1, 1'b0, 6'h23);
    cyc(1'b0, 1'b0, 6'h23); check_cycle("clr_mid", 2, 1'b0, 6'h23);
    cyc(1'b0, 1'b0, 6'h23); check_cycle("clr_mid", 3, 1'b0, 6'h23);
    cyc(1'b1, 1'b0, 6'h23);
    checks++;
    if (RegWrite !== 1'b0 || MemRead !== 1'b0) begin
      errors++;
      $display("FAIL clr_mid gating: RegWrite %b MemRead %b expected 0 0", RegWrite, MemRead);
    end
    run_instr("after_clr", 6'h23, 2, 1);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_back_to_back();
    test_random();
    test_trap(6'h3F);
`ifndef MC_CONTROL_BNE_EN
    test_trap(6'h05);
`endif
    test_clr_midwait();
    cyc(1'b0, 1'b1, 6'h00);
    check_cycle("final", 0, 1'b1, 6'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle control unit that sequences the CPU datapath (PC, IR, register file, ALU, unified memory) through per-instruction states.
- Replaces the single-cycle decode so that one memory port and one ALU are shared across cycles.
- Handshakes with a variable-latency memory via MemReady.
- Sits between the IR opcode field and the datapath mux/enable controls inside CPU.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_J, 6'h02, jump opcode
- OP_ADDI, 6'h08, add-immediate opcode

Ports:
- Clk in 1 rising-edge clock
- Clr in 1 synchronous active-high reset
- Op in 6 IR[31:26], valid from DECODE onward
- MemReady in 1 memory completes current access this cycle
- PCWrite out 1 unconditional PC load
- PCWriteCond out 1 PC load if ALU Zero (datapath ANDs)
- IorD out 1 0=PC address, 1=ALUOut address
- MemRead out 1 memory read request
- MemWrite out 1 memory write request
- IRWrite out 1 load IR
- MemtoReg out 1 register write data from MDR
- RegDst out 1 1=rd, 0=rt
- RegWrite out 1 register file write
- ALUSrcA out 1 0=PC, 1=A
- ALUSrcB out 2 0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
- ALUOp out 2 0=add, 1=sub, 2=use funct
- PCSource out 2 0=ALU, 1=ALUOut, 2=jump target
- Trap out 1 illegal opcode seen; sticky
- State out 4 current state, for debug

Behaviour:
- One clock, Clk. Reset is synchronous and active-high on Clr.
- State register encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=15.
- Clr=1 at a rising edge: State<=FETCH, Trap<=0, regardless of current state (including mid-wait and TRAP).
- While Clr=1, every write/request output (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) is forced 0. All other outputs are 0.
- Outputs are Moore-decoded from State, except IRWrite and PCWrite in FETCH, which are gated by MemReady. Unlisted outputs are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0; IRWrite=PCWrite=MemReady. Stay while MemReady=0; on MemReady=1 go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target precompute). Next state by Op:
  - LW/SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ -> BRANCH
  - J -> JUMP
  - ADDI -> ADDIEX
  - other -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next: LW -> MEMRD, SW -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until MemReady=1, then FETCH. MemWrite stays high throughout the wait.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Next RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=2. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- TRAP: all enables 0, Trap=1. Held until Clr.
- Zero-wait cycle counts (FETCH entry to next FETCH entry): R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemReady is ignored in all other states.
- MemRead and MemWrite are never high together.

Optional Feature:
- Macro: MC_CONTROL_BNE_EN.
- Defined: adds parameter OP_BNE=6'h05. DECODE routes BNE -> BRANCH, and a new output BranchNe (1 bit) is 1 in BRANCH when the current Op is BNE; the datapath then uses ~Zero.
- Undefined: opcode 6'h05 -> TRAP, and the BranchNe port is absent.

Decomposition:
- Package mc_pkg holds:
  - state encodings (localparam 4-bit)
  - ALUOp codes (ADD=0, SUB=1, FUNCT=2)
  - ALUSrcB codes
  - PCSource codes
- One natural sub-module, mc_next_state: combinational next-state function of (State, Op, MemReady).
- Output decode and the state register stay in mc_control.

Test Plan:
- Clr=1 for 2 cycles, then 0, MemReady=1 -> State=0, Trap=0; first cycle FETCH has MemRead=1, IRWrite=1, PCWrite=1.
- Op=6'h23, MemReady=1 -> states 0,1,2,3,4,0 (5 cycles); RegWrite=1 and MemtoReg=1 only in state 4.
- Op=6'h2B with MemReady low for 3 cycles in MEMWR -> MemWrite=1 for 4 consecutive cycles, IorD=1, then State=0.
- Op=6'h00 then 6'h04 then 6'h02 -> cycle counts 4, 3, 3.
  - ALUOp=2 in EXEC.
  - PCWriteCond=1 with PCSource=1 in BRANCH.
  - PCWrite=1 with PCSource=2 in JUMP.
- Op=6'h3F -> State=15, Trap=1 held for 10 cycles, all enables 0; Clr pulse -> State=0, Trap=0.
- Clr asserted in MEMRD while MemReady=0 -> next edge State=0, and no RegWrite occurs.
